mem_nport: RTL and testbench

Parametrised multi-read-port, single-write-port synchronous memory, the next generation of the processor's data/program store. It generalises data width, address width and read-port count, and registers all reads on the rising edge of `clk`. It defines read-during-write behaviour through a bypass mode. A reset-driven clear sequencer sweeps every location to a known value and reports progress on `busy`.

---
 rtl/mem_pkg.sv | 14 +
 rtl/mem_clear_ctl.sv | 66 ++++++
 rtl/mem_nport.sv | 95 +++++++++
 tb/tb_mem_nport.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared constants and state encoding for the multi-read-port memory and its
// clear sequencer.
package mem_pkg;

  localparam int MEM_DW = 8;
  localparam int MEM_AW = 8;
  localparam int MEM_NR = 2;

  typedef enum logic [0:0] {
    MEM_CLEAR = 1'b0,
    MEM_READY = 1'b1
  } mem_state_t;

endpackage

// File: rtl/mem_clear_ctl.sv
// Clear sequencer: after reset, sweeps every address once with a write strobe,
// then parks in READY until the next reset.
module mem_clear_ctl
  import mem_pkg::*;
#(
  parameter int AW = MEM_AW
) (
  input  logic          clk,
  input  logic          rst,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr,
  output logic          busy
);

  localparam logic [AW-1:0] CNT_LAST = {AW{1'b1}};
  localparam logic [AW-1:0] CNT_ONE  = {{(AW-1){1'b0}}, 1'b1};

  mem_state_t    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;

  // Next-state logic; the sweep write is suppressed while reset is held.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    clr_we  = 1'b0;
    case (state_q)
      MEM_CLEAR: begin
        clr_we = ~rst;
        cnt_d  = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = MEM_READY;
          busy_d  = 1'b0;
        end else begin
          busy_d  = 1'b1;
        end
      end
      MEM_READY: begin
        busy_d = 1'b0;
      end
      default: begin
        state_d = MEM_CLEAR;
        cnt_d   = '0;
        busy_d  = 1'b1;
      end
    endcase
  end

  // State, sweep counter and busy flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MEM_CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign clr_addr = cnt_q;
  assign busy     = busy_q;

endmodule

// File: rtl/mem_nport.sv
// NR-read / 1-write synchronous memory with registered reads, configurable
// read-during-write bypass and a reset-triggered clear sweep.
module mem_nport
  import mem_pkg::*;
#(
  parameter int             DW      = MEM_DW,
  parameter int             AW      = MEM_AW,
  parameter int             NR      = MEM_NR,
  parameter int             BYPASS  = 1,
  parameter logic [DW-1:0]  CLR_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [DW-1:0]    wr_data,
  input  logic [NR*AW-1:0] rd_addr,
  output logic [NR*DW-1:0] rd_data,
  output logic             busy
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0]    mem_q [DEPTH];
  logic             clr_we_s;
  logic [AW-1:0]    clr_addr_s;
  logic             busy_s;
  logic             user_we_s;
  logic             mem_we_s;
  logic [AW-1:0]    mem_waddr_s;
  logic [DW-1:0]    mem_wdata_s;
  logic [NR*DW-1:0] rd_data_d, rd_data_q;

  mem_clear_ctl #(
    .AW (AW)
  ) u_clear_ctl (
    .clk      (clk),
    .rst      (rst),
    .clr_we   (clr_we_s),
    .clr_addr (clr_addr_s),
    .busy     (busy_s)
  );

  assign user_we_s = wr_en & ~busy_s & ~rst;

  // Single physical write port: the sweep owns it while busy.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = wr_addr;
    mem_wdata_s = wr_data;
    if (clr_we_s) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = clr_addr_s;
      mem_wdata_s = CLR_VAL;
    end else begin
      mem_we_s    = user_we_s;
    end
  end

  // Storage array; intentionally not reset, the sweep initialises it.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // Per-port read mux with independent same-address bypass compare.
  always_comb begin
    rd_data_d = '0;
    if (!busy_s) begin
      for (int i = 0; i < NR; i++) begin
        if ((BYPASS != 0) && user_we_s && (wr_addr == rd_addr[i*AW +: AW])) begin
          rd_data_d[i*DW +: DW] = wr_data;
        end else begin
          rd_data_d[i*DW +: DW] = mem_q[rd_addr[i*AW +: AW]];
        end
      end
    end else begin
      rd_data_d = '0;
    end
  end

  // Registered read data, cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;
  assign busy    = busy_s;

endmodule

// File: tb/tb_mem_nport.sv
// Self-checking bench for mem_nport: write-first, read-first and four-port
// instances driven with shared writes and compared against an array model.
module tb_mem_nport;

  localparam int          AW    = 4;
  localparam int          DEPTH = 16;
  localparam logic [7:0]  CV    = 8'hA5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = 4'd0;
  logic [7:0]  wr_data = 8'd0;
  logic [7:0]  rd_addr2 = 8'd0;
  logic [15:0] rd_addr4 = 16'd0;
  logic [15:0] rd_b1, rd_b0;
  logic [31:0] rd_4;
  logic        busy_b1, busy_b0, busy_4;

  int checks = 0;
  int errors = 0;
  logic [7:0] model [DEPTH];

  typedef struct {
    logic       we;
    logic [3:0] wa;
    logic [7:0] wd;
    logic [3:0] a0;
    logic [3:0] a1;
    logic [7:0] e1_0;
    logic [7:0] e1_1;
    logic [7:0] e0_0;
    logic [7:0] e0_1;
  } vec_t;

  vec_t tbl [6];

  always #5 clk = ~clk;

  mem_nport #(.DW(8), .AW(AW), .NR(2), .BYPASS(1), .CLR_VAL(CV)) dut_b1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr2), .rd_data(rd_b1), .busy(busy_b1));

  mem_nport #(.DW(8), .AW(AW), .NR(2), .BYPASS(0), .CLR_VAL(CV)) dut_b0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr2), .rd_data(rd_b0), .busy(busy_b0));

  mem_nport #(.DW(8), .AW(AW), .NR(4), .BYPASS(1), .CLR_VAL(CV)) dut_4 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr4), .rd_data(rd_4), .busy(busy_4));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Expected read value of one port given the current write request.
  function automatic logic [7:0] exp_rd(input bit byp, input logic [3:0] a);
    if (byp && wr_en && (wr_addr == a)) return wr_data;
    return model[a];
  endfunction

  // Reset for 'hold' edges, optionally re-pulse reset after 'pulse_at' sweep
  // edges, then measure the sweep length while a stray write is requested.
  task automatic clear_seq(input int hold, input int pulse_at);
    int n;
    bit done;
    rst = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    chk("rst_busy", 32'({busy_b1, busy_b0, busy_4}), 32'h7);
    chk("rst_rd", 32'(rd_b1 | rd_b0 | rd_4[15:0] | rd_4[31:16]), 32'h0);
    rst = 1'b0;
    wr_en = 1'b1;
    wr_addr = 4'd2;
    wr_data = 8'hFF;
    if (pulse_at > 0) begin
      repeat (pulse_at) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("pulse_busy", 32'(busy_b1), 32'h1);
      rst = 1'b0;
    end
    n = 0;
    done = 1'b0;
    for (int e = 1; e <= 40 && !done; e++) begin
      @(posedge clk);
      #1;
      if (!busy_b1) begin
        done = 1'b1;
        n = e;
      end else begin
        chk("sweep_busy", 32'({busy_b0, busy_4}), 32'h3);
        chk("sweep_rd", 32'(rd_b1 | rd_b0 | rd_4[15:0] | rd_4[31:16]), 32'h0);
      end
    end
    chk("clear_len", 32'(n), 32'd16);
    chk("ready_busy", 32'({busy_b0, busy_4}), 32'h0);
    wr_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = CV;
  endtask

  task automatic readback();
    for (int i = 0; i < DEPTH; i++) begin
      rd_addr2 = {4'(15 - i), 4'(i)};
      rd_addr4 = {4'(i), 4'(i), 4'(i), 4'(i)};
      @(posedge clk);
      #1;
      chk("rb_b1", 32'(rd_b1), 32'({model[15 - i], model[i]}));
      chk("rb_b0", 32'(rd_b0), 32'({model[15 - i], model[i]}));
      chk("rb_4", rd_4, {model[i], model[i], model[i], model[i]});
    end
  endtask

  initial begin
    logic [7:0] nr4_val [4];
    logic [3:0] ra [4];
    logic [15:0] e1, e0;
    logic [31:0] e4;

    tbl[0] = '{1'b1, 4'd5, 8'h3C, 4'd5, 4'd6, 8'h3C, 8'hA5, 8'hA5, 8'hA5};
    tbl[1] = '{1'b0, 4'd0, 8'h00, 4'd5, 4'd5, 8'h3C, 8'h3C, 8'h3C, 8'h3C};
    tbl[2] = '{1'b1, 4'd7, 8'h11, 4'd0, 4'd1, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
    tbl[3] = '{1'b1, 4'd7, 8'h22, 4'd7, 4'd6, 8'h22, 8'hA5, 8'h11, 8'hA5};
    tbl[4] = '{1'b0, 4'd0, 8'h00, 4'd7, 4'd7, 8'h22, 8'h22, 8'h22, 8'h22};
    tbl[5] = '{1'b1, 4'd6, 8'h44, 4'd6, 4'd6, 8'h44, 8'h44, 8'hA5, 8'hA5};

    clear_seq(3, 0);
    readback();

    for (int k = 0; k < 6; k++) begin
      wr_en = tbl[k].we;
      wr_addr = tbl[k].wa;
      wr_data = tbl[k].wd;
      rd_addr2 = {tbl[k].a1, tbl[k].a0};
      @(posedge clk);
      #1;
      chk("tbl_b1", 32'(rd_b1), 32'({tbl[k].e1_1, tbl[k].e1_0}));
      chk("tbl_b0", 32'(rd_b0), 32'({tbl[k].e0_1, tbl[k].e0_0}));
      if (tbl[k].we) model[tbl[k].wa] = tbl[k].wd;
    end
    wr_en = 1'b0;

    nr4_val[0] = 8'hC1; nr4_val[1] = 8'hD2; nr4_val[2] = 8'hE3; nr4_val[3] = 8'hF4;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1;
      wr_addr = 4'(i);
      wr_data = nr4_val[i];
      @(posedge clk);
      #1;
      model[i] = nr4_val[i];
    end
    wr_en = 1'b0;
    rd_addr4 = {4'd0, 4'd1, 4'd2, 4'd3};
    @(posedge clk);
    #1;
    chk("nr4_rev", rd_4, {8'hC1, 8'hD2, 8'hE3, 8'hF4});

    for (int c = 0; c < 300; c++) begin
      wr_en = 1'($urandom_range(0, 1));
      wr_addr = 4'($urandom_range(0, 15));
      wr_data = 8'($urandom_range(0, 255));
      for (int p = 0; p < 4; p++) begin
        ra[p] = ($urandom_range(0, 2) == 0) ? wr_addr : 4'($urandom_range(0, 15));
      end
      rd_addr2 = {ra[1], ra[0]};
      rd_addr4 = {ra[3], ra[2], ra[1], ra[0]};
      e1 = {exp_rd(1'b1, ra[1]), exp_rd(1'b1, ra[0])};
      e0 = {exp_rd(1'b0, ra[1]), exp_rd(1'b0, ra[0])};
      e4 = {exp_rd(1'b1, ra[3]), exp_rd(1'b1, ra[2]), exp_rd(1'b1, ra[1]), exp_rd(1'b1, ra[0])};
      @(posedge clk);
      #1;
      chk("rnd_b1", 32'(rd_b1), 32'(e1));
      chk("rnd_b0", 32'(rd_b0), 32'(e0));
      chk("rnd_4", rd_4, e4);
      if (wr_en) model[wr_addr] = wr_data;
    end
    wr_en = 1'b0;

    clear_seq(1, 9);
    readback();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
